// File: rtl/pb_dummy_tile_resp_pkg.sv
// picobello_pkg: mesh geometry, link beat types, FSM states and the default error response code
package picobello_pkg;
  localparam int unsigned MeshX = 4;
  localparam int unsigned MeshY = 4;
  localparam int unsigned CoordXWidth = $clog2(MeshX);
  localparam int unsigned CoordYWidth = $clog2(MeshY);
  localparam int unsigned PbTxnIdWidth = 6;
  localparam logic [1:0] PbRespErr = 2'b11;
  typedef enum logic {ING_IDLE, ING_DRAIN} ing_state_e;
  typedef enum logic {EGR_IDLE, EGR_RESP} egr_state_e;
  typedef struct packed {
    logic is_hdr;
    logic is_write;
    logic [CoordXWidth-1:0] src_x;
    logic [CoordYWidth-1:0] src_y;
    logic [PbTxnIdWidth-1:0] txn_id;
    logic [7:0] len;
  } pb_dummy_req_t;
  typedef struct packed {
    logic is_write;
    logic [CoordXWidth-1:0] dst_x;
    logic [CoordYWidth-1:0] dst_y;
    logic [PbTxnIdWidth-1:0] txn_id;
    logic [1:0] resp;
    logic last;
  } pb_dummy_rsp_t;
  typedef struct packed {
    logic is_write;
    logic [CoordXWidth-1:0] src_x;
    logic [CoordYWidth-1:0] src_y;
    logic [PbTxnIdWidth-1:0] txn_id;
    logic [7:0] len;
  } pb_dummy_entry_t;
endpackage

// File: rtl/pb_dummy_tile_resp_if.sv
// pb_dummy_tile_resp_if: per-port link bundle (req_valid_i/req_ready_o/req_i in, rsp_valid_o/rsp_ready_i/rsp_o out); master = mesh, slave = responder
interface pb_dummy_tile_resp_if #(
  parameter int unsigned NumPorts = 4
) ();
  import picobello_pkg::*;
  logic [NumPorts-1:0] req_valid_i;
  logic [NumPorts-1:0] req_ready_o;
  pb_dummy_req_t [NumPorts-1:0] req_i;
  logic [NumPorts-1:0] rsp_valid_o;
  logic [NumPorts-1:0] rsp_ready_i;
  pb_dummy_rsp_t [NumPorts-1:0] rsp_o;
  modport master (output req_valid_i, req_i, rsp_ready_i, input req_ready_o, rsp_valid_o, rsp_o);
  modport slave (input req_valid_i, req_i, rsp_ready_i, output req_ready_o, rsp_valid_o, rsp_o);
endinterface

// File: rtl/pb_dummy_tile_resp_port.sv
// pb_dummy_tile_port: one link (req in, rsp out, stat_cnt if PB_DUMMY_TILE_STATS_EN) -- header capture, write-data drain, pending queue, error-response egress
module pb_dummy_tile_port
  import picobello_pkg::*;
#(
  parameter int unsigned QueueDepth = 4,
  parameter int unsigned TxnIdWidth = 6,
  parameter logic [1:0] RespErr = PbRespErr
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid,
  output logic          req_ready,
  input  pb_dummy_req_t req,
  output logic          rsp_valid,
  input  logic          rsp_ready,
`ifdef PB_DUMMY_TILE_STATS_EN
  output logic [15:0]   stat_cnt,
`endif
  output pb_dummy_rsp_t rsp
);
  localparam int unsigned Aw = $clog2(QueueDepth);
  pb_dummy_entry_t mem [QueueDepth];
  pb_dummy_entry_t head;
  logic [Aw-1:0] wptr, rptr;
  logic [Aw:0] used;
  ing_state_e ing_q, ing_d;
  egr_state_e egr_q, egr_d;
  logic [7:0] dcnt_q, dcnt_d, bcnt_q, bcnt_d;
  logic full, accept, push, pop, last;
  assign full = used == (Aw+1)'(QueueDepth);
  assign head = mem[rptr];
  always_comb begin
    ing_d = ing_q;
    dcnt_d = dcnt_q;
    req_ready = ing_q == ING_DRAIN || !full;
    accept = req_valid && req_ready;
    push = accept && ing_q == ING_IDLE && req.is_hdr;
    if (push && req.is_write) begin
      ing_d = ING_DRAIN;
      dcnt_d = req.len;
    end else if (accept && ing_q == ING_DRAIN) begin
      ing_d = dcnt_q == 8'd0 ? ING_IDLE : ING_DRAIN;
      dcnt_d = dcnt_q == 8'd0 ? 8'd0 : dcnt_q - 8'd1;
    end
  end
  always_comb begin
    egr_d = egr_q;
    bcnt_d = bcnt_q;
    rsp_valid = used != '0;
    last = head.is_write || bcnt_q == head.len;
    pop = rsp_valid && rsp_ready && last;
    if (rsp_valid && rsp_ready) begin
      egr_d = last ? EGR_IDLE : EGR_RESP;
      bcnt_d = last ? 8'd0 : bcnt_q + 8'd1;
    end
    rsp = rsp_valid ? pb_dummy_rsp_t'{is_write: head.is_write, dst_x: head.src_x, dst_y: head.src_y,
                                      txn_id: PbTxnIdWidth'(head.txn_id[TxnIdWidth-1:0]),
                                      resp: RespErr, last: last} : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ing_q <= ING_IDLE;
      egr_q <= EGR_IDLE;
      dcnt_q <= '0;
      bcnt_q <= '0;
      wptr <= '0;
      rptr <= '0;
      used <= '0;
    end else begin
      ing_q <= ing_d;
      egr_q <= egr_d;
      dcnt_q <= dcnt_d;
      bcnt_q <= bcnt_d;
      wptr <= wptr + Aw'(push);
      rptr <= rptr + Aw'(pop);
      used <= used + (Aw+1)'(push) - (Aw+1)'(pop);
    end
  end
  always_ff @(posedge clk_i) if (push) mem[wptr] <= '{is_write: req.is_write, src_x: req.src_x, src_y: req.src_y, txn_id: req.txn_id, len: req.len};
`ifdef PB_DUMMY_TILE_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) stat_cnt <= '0;
    else if (push && stat_cnt != 16'hFFFF) stat_cnt <= stat_cnt + 16'd1;
  end
`endif
endmodule

// File: rtl/pb_dummy_tile_resp.sv
// pb_dummy_tile_resp: error-responding dummy tile, NumPorts independent links (clk_i, rst_i, bus slave, stat_cnt_o if PB_DUMMY_TILE_STATS_EN)
module pb_dummy_tile_resp
  import picobello_pkg::*;
#(
  parameter int unsigned NumPorts = 4,
  parameter int unsigned QueueDepth = 4,
  parameter int unsigned TxnIdWidth = 6,
  parameter logic [1:0] RespErr = PbRespErr
) (
  input  logic clk_i,
  input  logic rst_i,
`ifdef PB_DUMMY_TILE_STATS_EN
  output logic [NumPorts-1:0][15:0] stat_cnt_o,
`endif
  pb_dummy_tile_resp_if.slave bus
);
  for (genvar i = 0; i < NumPorts; i++) begin : g_port
    pb_dummy_tile_port #(
      .QueueDepth(QueueDepth),
      .TxnIdWidth(TxnIdWidth),
      .RespErr(RespErr)
    ) u_port (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .req_valid(bus.req_valid_i[i]),
      .req_ready(bus.req_ready_o[i]),
      .req(bus.req_i[i]),
      .rsp_valid(bus.rsp_valid_o[i]),
      .rsp_ready(bus.rsp_ready_i[i]),
`ifdef PB_DUMMY_TILE_STATS_EN
      .stat_cnt(stat_cnt_o[i]),
`endif
      .rsp(bus.rsp_o[i])
    );
  end
endmodule

// File: tb/tb_pb_dummy_tile_resp.sv
// tb_pb_dummy_tile_resp: directed vectors, corner sequences and randomized traffic against a transaction-level model
module tb_pb_dummy_tile_resp;
  import picobello_pkg::*;
  localparam int NP = 4;
  localparam int QD = 4;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  pb_dummy_tile_resp_if #(.NumPorts(NP)) bus ();
`ifdef PB_DUMMY_TILE_STATS_EN
  logic [NP-1:0][15:0] stat_cnt;
`endif
  pb_dummy_tile_resp #(.NumPorts(NP), .QueueDepth(QD), .TxnIdWidth(6), .RespErr(2'b11)) dut (
    .clk_i(clk),
    .rst_i(rst),
`ifdef PB_DUMMY_TILE_STATS_EN
    .stat_cnt_o(stat_cnt),
`endif
    .bus(bus)
  );
  int checks = 0;
  int errors = 0;
  typedef struct {
    bit v, h, w;
    int len, id;
    bit rr;
    bit e_rdy, e_vld, e_last, e_wr;
    int e_id;
  } vec_t;
  typedef struct {
    bit w;
    int x, y, id, len;
  } txn_t;
  vec_t tab[13];
  txn_t pend[NP][$];
  int bidx[NP], rem[NP];
  task automatic check(string name, longint got, longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic drive(int p, bit v, bit h, bit w, int x, int y, int id, int len, bit rr);
    bus.req_valid_i[p] = v;
    bus.req_i[p] = '{is_hdr: h, is_write: w, src_x: CoordXWidth'(x), src_y: CoordYWidth'(y),
                     txn_id: PbTxnIdWidth'(id), len: 8'(len)};
    bus.rsp_ready_i[p] = rr;
  endtask
  task automatic idle_all(bit rr);
    for (int p = 0; p < NP; p++) drive(p, 0, 0, 0, 0, 0, 0, 0, rr);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_all(0);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask
  initial begin
    int beats, lasts, lastidx;
    rst = 1'b1;
    idle_all(0);
    do_reset();
    for (int p = 0; p < NP; p++) begin
      check("reset_ready", bus.req_ready_o[p], 1);
      check("reset_valid", bus.rsp_valid_o[p], 0);
      check("reset_rsp", bus.rsp_o[p], 0);
    end
    tab = '{
      '{1, 1, 0, 3, 5, 1, 1, 0, 0, 0, 0},
      '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 5},
      '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 5},
      '{0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 5},
      '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 5},
      '{1, 1, 1, 2, 9, 1, 1, 0, 0, 0, 0},
      '{1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 9},
      '{1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0},
      '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0},
      '{1, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0},
      '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 3},
      '{1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0},
      '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0}
    };
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(0, tab[i].v, tab[i].h, tab[i].w, 2, 1, tab[i].id, tab[i].len, tab[i].rr);
      #1;
      check("vec_ready", bus.req_ready_o[0], tab[i].e_rdy);
      check("vec_valid", bus.rsp_valid_o[0], tab[i].e_vld);
      if (tab[i].e_vld) begin
        check("vec_last", bus.rsp_o[0].last, tab[i].e_last);
        check("vec_write", bus.rsp_o[0].is_write, tab[i].e_wr);
        check("vec_txn", bus.rsp_o[0].txn_id, tab[i].e_id);
        check("vec_dst_x", bus.rsp_o[0].dst_x, 2);
        check("vec_dst_y", bus.rsp_o[0].dst_y, 1);
        check("vec_resp", bus.rsp_o[0].resp, 3);
      end else check("vec_rsp_zero", bus.rsp_o[0], 0);
    end
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(0, 1, 1, 0, 1, 1, k, 0, 0);
      #1;
      check("full_ready", bus.req_ready_o[0], k < 4);
    end
    @(negedge clk);
    drive(0, 1, 1, 0, 1, 1, 4, 0, 1);
    #1;
    check("full_ready_held", bus.req_ready_o[0], 0);
    check("full_head", bus.rsp_o[0].txn_id, 0);
    @(negedge clk);
    #1;
    check("full_ready_after_pop", bus.req_ready_o[0], 1);
    check("full_head1", bus.rsp_o[0].txn_id, 1);
    for (int k = 2; k < 5; k++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1;
      check("full_order_valid", bus.rsp_valid_o[0], 1);
      check("full_order_txn", bus.rsp_o[0].txn_id, k);
    end
    @(negedge clk);
    #1;
    check("full_empty", bus.rsp_valid_o[0], 0);
    do_reset();
    @(negedge clk);
    drive(0, 1, 1, 0, 3, 2, 7, 7, 1);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1;
      check("rst_burst_valid", bus.rsp_valid_o[0], 1);
      check("rst_burst_last", bus.rsp_o[0].last, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_valid", bus.rsp_valid_o[0], 0);
    check("rst_mid_ready", bus.req_ready_o[0], 1);
    @(negedge clk);
    drive(0, 1, 1, 0, 1, 3, 12, 0, 1);
    #1;
    check("rst_no_more_beats", bus.rsp_valid_o[0], 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    check("rst_new_valid", bus.rsp_valid_o[0], 1);
    check("rst_new_txn", bus.rsp_o[0].txn_id, 12);
    check("rst_new_last", bus.rsp_o[0].last, 1);
    do_reset();
    @(negedge clk);
    drive(0, 1, 1, 0, 0, 0, 1, 255, 1);
    beats = 0;
    lasts = 0;
    lastidx = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      #1;
      if (bus.rsp_valid_o[0]) begin
        if (bus.rsp_o[0].last) begin
          lasts++;
          lastidx = beats;
        end
        beats++;
      end
    end
    check("len255_beats", beats, 256);
    check("len255_lasts", lasts, 1);
    check("len255_lastidx", lastidx, 255);
    do_reset();
    for (int p = 0; p < NP; p++) begin
      pend[p].delete();
      bidx[p] = 0;
      rem[p] = -1;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit vv[NP], hh[NP], ww[NP], rr[NP];
      int xx[NP], yy[NP], ii[NP], ll[NP];
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        vv[p] = $urandom_range(0, 3) != 0;
        hh[p] = $urandom_range(0, 4) != 0;
        ww[p] = $urandom_range(0, 1) != 0;
        xx[p] = $urandom_range(0, 3);
        yy[p] = $urandom_range(0, 3);
        ii[p] = $urandom_range(0, 63);
        ll[p] = $urandom_range(0, 4);
        rr[p] = (p == 3 && cyc < 1500) ? 1'b0 : $urandom_range(0, 3) != 0;
        drive(p, vv[p], hh[p], ww[p], xx[p], yy[p], ii[p], ll[p], rr[p]);
      end
      #1;
      for (int p = 0; p < NP; p++) begin
        bit exp_rdy, exp_vld, elast;
        txn_t hd;
        pb_dummy_rsp_t er;
        exp_rdy = rem[p] >= 0 || pend[p].size() < QD;
        exp_vld = pend[p].size() > 0;
        elast = 1'b0;
        check("rnd_ready", bus.req_ready_o[p], exp_rdy);
        check("rnd_valid", bus.rsp_valid_o[p], exp_vld);
        if (exp_vld) begin
          hd = pend[p][0];
          elast = hd.w || bidx[p] == hd.len;
          er = '{is_write: hd.w, dst_x: CoordXWidth'(hd.x), dst_y: CoordYWidth'(hd.y),
                 txn_id: PbTxnIdWidth'(hd.id), resp: 2'b11, last: elast};
          check("rnd_rsp", bus.rsp_o[p], er);
          if (rr[p]) begin
            if (elast) begin
              void'(pend[p].pop_front());
              bidx[p] = 0;
            end else bidx[p]++;
          end
        end else check("rnd_rsp_zero", bus.rsp_o[p], 0);
        if (vv[p] && exp_rdy) begin
          if (rem[p] >= 0) rem[p]--;
          else if (hh[p]) begin
            pend[p].push_back('{w: ww[p], x: xx[p], y: yy[p], id: ii[p], len: ll[p]});
            if (ww[p]) rem[p] = ll[p];
          end
        end
      end
    end
`ifdef PB_DUMMY_TILE_STATS_EN
    do_reset();
    for (int p = 0; p < NP; p++) check("stat_reset", stat_cnt[p], 0);
    for (int c = 0; c < 70000; c++) begin
      @(negedge clk);
      drive(1, 1, 1, 0, 0, 0, c % 64, 0, 1);
    end
    @(negedge clk);
    idle_all(1);
    #1;
    for (int p = 0; p < NP; p++) check("stat_sat", stat_cnt[p], p == 1 ? 16'hFFFF : 16'h0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pb_dummy_tile_resp.md
PB_DUMMY_TILE_RESP -- requirements
Module: pb_dummy_tile_resp

Interface
REQ-001 Parameter NumPorts, default 4, SHALL set the number of independent mesh link ports (1..4, one per direction).
REQ-002 Parameter QueueDepth, default 4, SHALL set the pending-response queue depth per port (power of two, >=2).
REQ-003 Parameter TxnIdWidth, default 6, SHALL set the transaction-ID width.
REQ-004 Parameter RespErr, default 2'b11 (DECERR), SHALL set the response code returned for every transaction.
REQ-005 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst_i  in  1  reset, synchronous and active-high.
REQ-007 req_valid_i  in  NumPorts  incoming beat valid, per port.
REQ-008 req_ready_o  out  NumPorts  incoming beat ready, per port.
REQ-009 req_i  in  NumPorts x pb_dummy_req_t  beat with fields is_hdr, is_write, src_x, src_y, txn_id, len[7:0].
REQ-010 rsp_valid_o  out  NumPorts  response beat valid.
REQ-011 rsp_ready_i  in  NumPorts  response beat ready.
REQ-012 rsp_o  out  NumPorts x pb_dummy_rsp_t  fields is_write, dst_x, dst_y, txn_id, resp[1:0], last.

Function
REQ-013 Ports SHALL operate fully independently; no arbitration between ports.
REQ-014 Ingress FSM per port SHALL have states IDLE, DRAIN; reset state IDLE.
REQ-015 IDLE: header beat (is_hdr=1) SHALL be accepted only when the response queue is not full; req_ready_o=0 when full.
REQ-016 Accepted header SHALL push {is_write, src_x, src_y, txn_id, len} into the queue in the same cycle.
REQ-017 Write header SHALL move IDLE->DRAIN with beat counter = len; read header SHALL stay in IDLE.
REQ-018 DRAIN: req_ready_o=1 unconditionally; each accepted data beat decrements the counter; beat accepted at counter 0 SHALL return to IDLE.
REQ-019 Non-header beat in IDLE SHALL be accepted and discarded; header beat in DRAIN SHALL be consumed as data (protocol error, no recovery).
REQ-020 Egress FSM per port, states IDLE, RESP: queue head read -> emit len+1 beats with last on the final beat; write -> emit exactly one beat with last=1.
REQ-021 Every response beat SHALL carry dst = stored src, stored txn_id, resp=RespErr.
REQ-022 rsp_valid_o once asserted SHALL stay high with rsp_o stable until rsp_ready_i; queue pop on handshake of the last beat.
REQ-023 Earliest response: first rsp_valid_o one cycle after the header handshake (registered queue, no fall-through).
REQ-024 Simultaneous push and pop on a full queue SHALL NOT occur (push gated by full); push and pop on a non-full queue SHALL both take effect.
REQ-025 Read burst counter SHALL be 8 bits, counting 0..len without overflow; len=255 yields 256 beats.

Reset
REQ-026 On rst_i=1 at a clock edge: both FSMs IDLE, queues empty, counters 0, req_ready_o=all 1s, rsp_valid_o=0, rsp_o=0.
REQ-027 Reset mid-burst SHALL abandon all pending transactions with no further response beats.

Configuration
REQ-028 Macro PB_DUMMY_TILE_STATS_EN defined: output stat_cnt_o (NumPorts x 16 bits) SHALL count accepted headers per port, saturating at 16'hFFFF, cleared by reset.
REQ-029 Macro undefined: stat_cnt_o and its counters SHALL be absent; all other behaviour identical.

Structure
REQ-030 pb_dummy_req_t, pb_dummy_rsp_t and the RespErr default SHALL live in picobello_pkg, coordinate widths derived from the mesh dimensions there.
REQ-031 Per-port logic SHALL be one sub-module pb_dummy_tile_port, instantiated NumPorts times in a generate loop.

Verification
REQ-032 Read header len=3 txn_id=5 src=(2,1), rsp_ready=1 -> 4 beats dst=(2,1) id=5 resp=2'b11, last only on 4th, first beat 1 cycle after header.
REQ-033 Write header len=2 + 3 data beats -> exactly one beat is_write=1 last=1 resp=2'b11, emitted after header acceptance independent of drain.
REQ-034 QueueDepth=4, rsp_ready=0, 5 read headers -> 4 accepted, req_ready_o=0 on 5th; raise rsp_ready -> 5th accepted after first pop.
REQ-035 Traffic on ports 0 and 3 concurrently, port 3 rsp_ready held 0 -> port 0 responses unaffected, no cross-port ordering.
REQ-036 rst_i asserted mid read burst (beat 2 of 8) -> next cycle rsp_valid_o=0, queue empty; new header afterwards served normally.
REQ-037 With PB_DUMMY_TILE_STATS_EN, 70000 headers on port 1 -> stat_cnt_o[1]=16'hFFFF, others 0.
